// File: rtl/count_mon_pkg.sv
// Shared constants and types for the count event monitor: record kinds,
// FSM state encoding and event record width.
package count_mon_pkg;

    localparam logic [1:0] KIND_WRAP = 2'b01;
    localparam logic [1:0] KIND_JUMP = 2'b10;

    localparam int CNT_W_DEF   = 4;
    localparam int EPOCH_W_DEF = 8;
    localparam int REC_W       = 2 + EPOCH_W_DEF + CNT_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    // Record layout is {kind[1:0], epoch, value}.
    function automatic int rec_width(input int cnt_w, input int epoch_w);
        return 2 + epoch_w + cnt_w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers for the full/empty test.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; rdata is masked while empty,
    // so stale entries are never visible after a reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/count_event_monitor.sv
// Watches a down-counter bus, classifies each transition and queues wrap/jump
// records for a valid/ready consumer; keeps a wrap epoch and a sticky drop flag.
module count_event_monitor
    import count_mon_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int EPOCH_W    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [0:CNT_W-1]         count,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [EPOCH_W+CNT_W+1:0] evt_data,
    output logic [EPOCH_W-1:0]       epoch,
    output logic                     ovf,
    input  logic                     clr_ovf
);

    localparam int                 RW        = rec_width(CNT_W, EPOCH_W);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [EPOCH_W-1:0] EPOCH_ONE = {{(EPOCH_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  prev;
    logic [EPOCH_W-1:0] epoch_inc;
    logic              tracking;
    logic              is_hold;
    logic              is_step;
    logic              is_wrap;
    logic              is_jump;
    logic              push;
    logic              pop;
    logic              drop;
    logic              full;
    logic              empty;
    logic [RW-1:0]     rec;

    always_comb begin
        // count[0] is the MSB, so a plain assignment keeps numeric order
        cnt       = count;
        epoch_inc = epoch + EPOCH_ONE;
        tracking  = (state == ST_TRACK) && en;
        is_hold   = (cnt == prev);
        is_step   = (prev != '0) && (cnt == prev - CNT_ONE);
        is_wrap   = (prev == '0) && (cnt == CNT_MAX);
        is_jump   = !is_hold && !is_step && !is_wrap;
        push      = tracking && (is_wrap || is_jump);
        rec       = is_wrap ? {KIND_WRAP, epoch_inc, cnt} : {KIND_JUMP, epoch, cnt};
        pop       = evt_valid && evt_ready;
        drop      = push && full && !pop;
    end

    assign evt_valid = !empty;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            prev  <= '0;
            epoch <= '0;
            ovf   <= 1'b0;
        end else begin
            if (!en) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE:  state <= ST_PRIME;
                    ST_PRIME: begin
                        prev  <= cnt;
                        state <= ST_TRACK;
                    end
                    ST_TRACK: prev <= cnt;
                    default:  state <= ST_IDLE;
                endcase
            end
            // Epoch advances even when the wrap record itself is dropped
            if (tracking && is_wrap) epoch <= epoch_inc;
            if (drop)         ovf <= 1'b1;
            else if (clr_ovf) ovf <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (rec),
        .rdata (evt_data),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_count_event_monitor.sv
// Self-checking bench for count_event_monitor: a table of count transitions
// plus hand-written sequences for overflow, full-FIFO, enable and reset corners.
module tb_count_event_monitor;
    import count_mon_pkg::*;

    typedef logic [REC_W-1:0] rec_t;
    typedef struct packed {
        logic       en;
        logic [3:0] cnt;
        logic       push;
        logic [1:0] kind;
        logic [7:0] ep;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [0:3] count;
    logic       evt_valid;
    logic       evt_ready;
    rec_t       evt_data;
    logic [7:0] epoch;
    logic       ovf;
    logic       clr_ovf;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pops   = 0;
    rec_t exp_q[$];
    vec_t tbl[18];

    count_event_monitor dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .count     (count),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .epoch     (epoch),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic rec_t mk(input logic [1:0] k, input logic [7:0] e, input logic [3:0] v);
        return {k, e, v};
    endfunction

    // Drive one cycle of stimulus; the scoreboard looks at the head at the
    // negedge, then the task returns just after the rising edge.
    task automatic tick(input logic e, input logic [3:0] c, input logic r, input logic cl);
        rec_t head;
        en        = e;
        count     = c;
        evt_ready = r;
        clr_ovf   = cl;
        @(negedge clk);
        if (evt_valid) begin
            if (evt_ready) begin
                if (exp_q.size() == 0) begin
                    check("evt_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    head = exp_q.pop_front();
                    n_pops++;
                    check("evt_pop", 32'(evt_data), 32'(head));
                end
            end else if (exp_q.size() != 0) begin
                check("evt_head_hold", 32'(evt_data), 32'(exp_q[0]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        en        = 1'b0;
        count     = 4'd0;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
    endtask

    task automatic drain(input logic [3:0] c);
        for (int i = 0; i < 12 && exp_q.size() != 0; i++) tick(1'b1, c, 1'b1, 1'b0);
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_valid", 32'(evt_valid), 32'd0);
    endtask

    // From TRACK with prev=15, step down to 0 and wrap back to 15.
    task automatic wrap_once(input logic r, input logic cl);
        for (int c = 14; c >= 0; c--) tick(1'b1, 4'(c), 1'b0, 1'b0);
        tick(1'b1, 4'd15, r, cl);
    endtask

    initial begin
        tbl = '{
            '{1'b1, 4'd3,  1'b0, 2'b00, 8'd0},
            '{1'b1, 4'd3,  1'b0, 2'b00, 8'd0},
            '{1'b1, 4'd3,  1'b0, 2'b00, 8'd0},
            '{1'b1, 4'd2,  1'b0, 2'b00, 8'd0},
            '{1'b1, 4'd1,  1'b0, 2'b00, 8'd0},
            '{1'b1, 4'd0,  1'b0, 2'b00, 8'd0},
            '{1'b1, 4'd15, 1'b1, 2'b01, 8'd1},
            '{1'b1, 4'd14, 1'b0, 2'b00, 8'd1},
            '{1'b1, 4'd13, 1'b0, 2'b00, 8'd1},
            '{1'b1, 4'd12, 1'b0, 2'b00, 8'd1},
            '{1'b1, 4'd11, 1'b0, 2'b00, 8'd1},
            '{1'b1, 4'd10, 1'b0, 2'b00, 8'd1},
            '{1'b1, 4'd9,  1'b0, 2'b00, 8'd1},
            '{1'b1, 4'd15, 1'b1, 2'b10, 8'd1},
            '{1'b1, 4'd14, 1'b0, 2'b00, 8'd1},
            '{1'b1, 4'd7,  1'b1, 2'b10, 8'd1},
            '{1'b1, 4'd0,  1'b1, 2'b10, 8'd1},
            '{1'b1, 4'd15, 1'b1, 2'b01, 8'd2}
        };

        // Reset state
        do_reset();
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_data", 32'(evt_data), 32'd0);
        check("rst_epoch", 32'(epoch), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        // Table: decrements, wrap, jumps from a counter reset and arbitrary values
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].push) exp_q.push_back(mk(tbl[i].kind, tbl[i].ep, tbl[i].cnt));
            tick(tbl[i].en, tbl[i].cnt, 1'b1, 1'b0);
            check("tbl_epoch", 32'(epoch), 32'(tbl[i].ep));
        end
        drain(4'd15);
        check("tbl_ovf", 32'(ovf), 32'd0);

        // Overflow: six wraps into a 4-deep FIFO with the consumer stalled
        do_reset();
        tick(1'b1, 4'd15, 1'b0, 1'b0);
        tick(1'b1, 4'd15, 1'b0, 1'b0);
        for (int w = 1; w <= 6; w++) begin
            if (w <= 4) exp_q.push_back(mk(KIND_WRAP, 8'(w), 4'd15));
            wrap_once(1'b0, w == 6);
            check("ovf_epoch", 32'(epoch), 32'(w));
            check("ovf_flag", 32'(ovf), (w >= 5) ? 32'd1 : 32'd0);
        end
        drain(4'd15);
        check("ovf_kept", 32'(ovf), 32'd1);
        tick(1'b1, 4'd15, 1'b1, 1'b1);
        check("ovf_clear", 32'(ovf), 32'd0);

        // Full FIFO: push and pop on the same edge must not drop
        do_reset();
        tick(1'b1, 4'd15, 1'b0, 1'b0);
        tick(1'b1, 4'd15, 1'b0, 1'b0);
        for (int w = 1; w <= 4; w++) begin
            exp_q.push_back(mk(KIND_WRAP, 8'(w), 4'd15));
            wrap_once(1'b0, 1'b0);
        end
        exp_q.push_back(mk(KIND_WRAP, 8'd5, 4'd15));
        wrap_once(1'b1, 1'b0);
        check("full_ovf", 32'(ovf), 32'd0);
        check("full_epoch", 32'(epoch), 32'd5);
        n_pops = 0;
        drain(4'd15);
        check("full_occupancy", 32'(n_pops), 32'd4);

        // Enable low across a wrap, re-enabled mid-count: no false event
        do_reset();
        tick(1'b1, 4'd1, 1'b1, 1'b0);
        tick(1'b1, 4'd1, 1'b1, 1'b0);
        tick(1'b1, 4'd1, 1'b1, 1'b0);
        tick(1'b1, 4'd0, 1'b1, 1'b0);
        for (int c = 16; c >= 12; c--) tick(1'b0, 4'(c), 1'b1, 1'b0);
        tick(1'b1, 4'd12, 1'b1, 1'b0);
        tick(1'b1, 4'd12, 1'b1, 1'b0);
        tick(1'b1, 4'd11, 1'b1, 1'b0);
        check("en_epoch", 32'(epoch), 32'd0);
        check("en_no_evt", 32'(evt_valid), 32'd0);
        exp_q.push_back(mk(KIND_JUMP, 8'd0, 4'd15));
        tick(1'b1, 4'd15, 1'b1, 1'b0);
        drain(4'd15);

        // Asynchronous reset in the middle of a drain
        do_reset();
        tick(1'b1, 4'd1, 1'b0, 1'b0);
        tick(1'b1, 4'd1, 1'b0, 1'b0);
        tick(1'b1, 4'd0, 1'b0, 1'b0);
        exp_q.push_back(mk(KIND_WRAP, 8'd1, 4'd15));
        tick(1'b1, 4'd15, 1'b0, 1'b0);
        exp_q.push_back(mk(KIND_JUMP, 8'd1, 4'd7));
        tick(1'b1, 4'd7, 1'b0, 1'b0);
        exp_q.push_back(mk(KIND_JUMP, 8'd1, 4'd3));
        tick(1'b1, 4'd3, 1'b0, 1'b0);
        exp_q.push_back(mk(KIND_JUMP, 8'd1, 4'd9));
        tick(1'b1, 4'd9, 1'b0, 1'b0);
        tick(1'b1, 4'd2, 1'b0, 1'b0);
        check("mid_ovf_set", 32'(ovf), 32'd1);
        tick(1'b1, 4'd2, 1'b1, 1'b0);
        check("mid_queued", 32'(exp_q.size()), 32'd3);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(evt_valid), 32'd0);
        check("mid_rst_epoch", 32'(epoch), 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        check("mid_rst_data", 32'(evt_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        tick(1'b0, 4'd2, 1'b1, 1'b0);
        check("post_rst_valid", 32'(evt_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
